// File: rtl/uart_tx_feeder_pkg.sv
// Shared constants and FSM state encoding for the UART transmit feeder.
package uart_tx_feeder_pkg;

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned BYTE_W        = 8;

  localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
  localparam logic [1:0] ST_ISSUE_ENC     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY_ENC = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_ISSUE     = ST_ISSUE_ENC,
    ST_WAIT_BUSY = ST_WAIT_BUSY_ENC,
    ST_WAIT_DONE = ST_WAIT_DONE_ENC
  } state_e;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock byte FIFO; count/full/empty are registered, head byte is a
// combinational read of the entry at the read pointer.
module sync_fifo_8
  import uart_tx_feeder_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_head_data_c,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_push_ok;
  logic              w_pop_ok;
  logic [CW-1:0]     w_count_next;

  // A push while full is refused even when a pop frees a slot this cycle.
  assign w_push_ok    = i_push && !r_full;
  assign w_pop_ok     = i_pop && !r_empty;
  assign w_count_next = r_count + CW'(w_push_ok) - CW'(w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_data_c = r_mem[r_rd_ptr];
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_count       = r_count;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to the UART transmitter
// over its start/data/ready handshake.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              busy
);

  state_e            r_state;
  state_e            w_state_next;
  logic              w_pop;
  logic [BYTE_W-1:0] w_head_data;
  logic              r_overflow;
  logic              r_tx_start;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_busy;

  sync_fifo_8 #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (wr_en),
    .i_push_data   (wr_data),
    .i_pop         (w_pop),
    .o_head_data_c (w_head_data),
    .o_full        (full),
    .o_empty       (empty),
    .o_count       (count)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // WAIT_BUSY covers the transmitter's lag between start and ready falling.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!empty && tx_ready) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE:     w_state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!tx_ready) w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_ready)  w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (wr_en & full);
      r_tx_start <= w_pop;
      if (w_pop) r_tx_data <= w_head_data;
      r_busy     <= (w_state_next != ST_IDLE);
    end
  end

  assign overflow = r_overflow;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed table, hand sequences and
// random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx_ready = 1'b1;
  logic          full, empty, overflow, tx_start, busy;
  logic [AW:0]   count;
  logic [7:0]    tx_data;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: byte queue plus "frame in flight" bookkeeping.
  logic [7:0] m_q[$];
  bit         m_in_flight, m_issue, m_seen_low, m_ovf, m_start;
  logic [7:0] m_data;

  // Transmitter stimulus and observed-pulse log.
  int         tx_wait = 0, tx_low = 0, tx_drop_dly = 3, tx_low_len = 4;
  bit         tx_stall = 0;
  logic [7:0] p_data[$];
  int         p_cyc[$];
  bit         f_low, f_done;
  int         seq_pulses = 0;

  typedef struct {
    bit         wr;
    logic [7:0] d;
    bit         rdy;
    int         e_count;
    bit         e_start;
    bit         e_busy;
    logic [7:0] e_data;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_edge(input bit r, input bit w, input logic [7:0] d, input bit rdy);
    bit acc, pop;
    if (r) begin
      m_q.delete();
      m_in_flight = 0; m_issue = 0; m_seen_low = 0;
      m_ovf = 0; m_start = 0; m_data = 8'h00;
      return;
    end
    acc = w && (m_q.size() != DEPTH);
    if (w && m_q.size() == DEPTH) m_ovf = 1;
    pop = !m_in_flight && (m_q.size() != 0) && rdy;
    if (m_in_flight) begin
      if (m_issue) m_issue = 0;
      else if (!m_seen_low) begin
        if (!rdy) m_seen_low = 1;
      end else if (rdy) begin
        m_in_flight = 0;
        m_seen_low  = 0;
      end
    end
    m_start = pop;
    if (pop) begin
      m_data      = m_q.pop_front();
      m_in_flight = 1;
      m_issue     = 1;
    end
    if (acc) m_q.push_back(d);
  endfunction

  task automatic tick(input bit r, input bit w, input logic [7:0] d, input bit rdy);
    rst = r; wr_en = w; wr_data = d; tx_ready = rdy;
    @(posedge clk);
    model_edge(r, w, d, rdy);
    cyc++;
    #1;
    chk("count",    32'(count),    32'(m_q.size()));
    chk("full",     32'(full),     32'(m_q.size() == DEPTH));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("busy",     32'(busy),     32'(m_in_flight));
    chk("tx_data",  32'(tx_data),  32'(m_data));
    // A new pulse must follow a full low->high ready cycle of the previous frame.
    if (r) seq_pulses = 0;
    else if (!rdy) f_low = 1;
    else if (f_low) f_done = 1;
    if (tx_start === 1'b1) begin
      if (seq_pulses > 0) chk("frame_gap", 32'(f_done), 32'd1);
      seq_pulses++;
      f_low = 0; f_done = 0;
      p_data.push_back(tx_data);
      p_cyc.push_back(cyc);
    end
    if (tx_low > 0) tx_low--;
    if (tx_wait > 0) begin
      tx_wait--;
      if (tx_wait == 0) tx_low = tx_low_len;
    end
    if (m_start) tx_wait = tx_drop_dly;
  endtask

  task automatic auto_tick(input bit w, input logic [7:0] d);
    tick(1'b0, w, d, (tx_low == 0) && !tx_stall);
  endtask

  task automatic reset_dut();
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    p_data.delete(); p_cyc.delete();
    seq_pulses = 0; tx_wait = 0; tx_low = 0; tx_stall = 0;
  endtask

  task automatic drain(input int limit, input string name);
    int n;
    n = 0;
    while ((m_q.size() != 0 || m_in_flight) && n < limit) begin
      auto_tick(1'b0, 8'h00);
      n++;
    end
    chk({name, "_idle_busy"},  32'(busy),  32'd0);
    chk({name, "_idle_count"}, 32'(count), 32'd0);
  endtask

  task automatic add_vec(input bit wr, input logic [7:0] d, input bit rdy, input int ec,
                         input bit es, input bit eb, input logic [7:0] ed);
    vec_t v;
    v.wr = wr; v.d = d; v.rdy = rdy; v.e_count = ec; v.e_start = es; v.e_busy = eb; v.e_data = ed;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;

    // Reset state
    reset_dut();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);

    // Directed table: single byte handshake, then simultaneous write+pop
    add_vec(1, 8'hA5, 1, 1, 0, 0, 8'h00);
    add_vec(0, 8'h00, 1, 0, 1, 1, 8'hA5);
    add_vec(0, 8'h00, 1, 0, 0, 1, 8'hA5);
    add_vec(0, 8'h00, 1, 0, 0, 1, 8'hA5);
    add_vec(0, 8'h00, 0, 0, 0, 1, 8'hA5);
    add_vec(0, 8'h00, 0, 0, 0, 1, 8'hA5);
    add_vec(0, 8'h00, 1, 0, 0, 0, 8'hA5);
    add_vec(1, 8'h11, 0, 1, 0, 0, 8'hA5);
    add_vec(1, 8'h3C, 1, 1, 1, 1, 8'h11);
    add_vec(0, 8'h00, 1, 1, 0, 1, 8'h11);
    add_vec(0, 8'h00, 0, 1, 0, 1, 8'h11);
    add_vec(0, 8'h00, 1, 1, 0, 0, 8'h11);
    add_vec(0, 8'h00, 1, 0, 1, 1, 8'h3C);
    add_vec(0, 8'h00, 0, 0, 0, 1, 8'h3C);
    add_vec(0, 8'h00, 1, 0, 0, 1, 8'h3C);
    add_vec(0, 8'h00, 0, 0, 0, 1, 8'h3C);
    add_vec(0, 8'h00, 1, 0, 0, 0, 8'h3C);
    for (int i = 0; i < tbl.size(); i++) begin
      tick(1'b0, tbl[i].wr, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_count", i), 32'(count),    32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_start", i), 32'(tx_start), 32'(tbl[i].e_start));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),     32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_data", i),  32'(tx_data),  32'(tbl[i].e_data));
    end

    // Single byte with a slow transmitter (ready low for 20 cycles)
    reset_dut();
    tx_drop_dly = 3; tx_low_len = 20;
    auto_tick(1'b1, 8'hA5);
    c1 = cyc;
    drain(200, "single");
    chk("single_pulses", 32'(p_data.size()), 32'd1);
    if (p_data.size() == 1) begin
      chk("single_data",  32'(p_data[0]), 32'hA5);
      chk("single_delay", 32'(p_cyc[0]),  32'(c1 + 1));
    end

    // Burst of five bytes
    reset_dut();
    tx_drop_dly = 2; tx_low_len = 5;
    for (int i = 1; i <= 5; i++) auto_tick(1'b1, 8'(i));
    drain(400, "burst");
    chk("burst_pulses", 32'(p_data.size()), 32'd5);
    for (int i = 0; i < p_data.size() && i < 5; i++)
      chk($sformatf("burst_data%0d", i), 32'(p_data[i]), 32'(i + 1));

    // Fill past DEPTH with the transmitter stalled
    reset_dut();
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
      if (i == DEPTH - 1) begin
        chk("fill_full",  32'(full),     32'd1);
        chk("fill_count", 32'(count),    32'(DEPTH));
        chk("fill_ovf0",  32'(overflow), 32'd0);
      end
      if (i == DEPTH) chk("fill_ovf1", 32'(overflow), 32'd1);
    end
    tx_drop_dly = 1; tx_low_len = 2;
    drain(1000, "fill");
    chk("fill_ovf_sticky", 32'(overflow), 32'd1);
    chk("fill_pulses", 32'(p_data.size()), 32'(DEPTH));
    for (int i = 0; i < p_data.size() && i < DEPTH; i++)
      chk($sformatf("fill_data%0d", i), 32'(p_data[i]), 32'(8'h40 + i));

    // Reset while waiting for ready to fall, three bytes queued
    reset_dut();
    tick(1'b0, 1'b1, 8'hB0, 1'b1);
    tick(1'b0, 1'b1, 8'hB1, 1'b1);
    tick(1'b0, 1'b1, 8'hB2, 1'b1);
    tick(1'b0, 1'b1, 8'hB3, 1'b1);
    chk("mid_count_pre", 32'(count), 32'd3);
    chk("mid_busy_pre",  32'(busy),  32'd1);
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    chk("mid_count", 32'(count),    32'd0);
    chk("mid_busy",  32'(busy),     32'd0);
    chk("mid_start", 32'(tx_start), 32'd0);
    p_data.delete(); p_cyc.delete();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("mid_no_pulse", 32'(p_data.size()), 32'd0);

    // Random traffic against the model
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      tx_drop_dly = $urandom_range(1, 4);
      tx_low_len  = $urandom_range(1, 10);
      if ($urandom_range(0, 199) == 0) tx_stall = !tx_stall;
      if ($urandom_range(0, 599) == 0) tick(1'b1, 1'b0, 8'h00, 1'b1);
      else auto_tick($urandom_range(0, 99) < 35, 8'($urandom));
    end
    tx_stall = 0;
    drain(1000, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
